// File: rtl/seq_array_mult_pkg.sv
// ----------------------------------------------------------------------------
// mult_pkg
// Shared types and helpers for the sequential shift-add multiplier.
//   state_e  : controller states (IDLE, BUSY, DONE)
//   abs_mag  : magnitude of a WIDTH-bit operand (signed or unsigned view)
//   neg2c    : two's-complement negation of a product-sized vector
// Helpers work on the widest legal vectors; callers cast to their own width.
// ----------------------------------------------------------------------------
package mult_pkg;

  localparam int MAX_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  // value must be zero-extended above bit width-1. The most negative operand
  // maps to 2^(width-1), which still fits unsigned in width bits.
  function automatic logic [MAX_W-1:0] abs_mag(input logic [MAX_W-1:0] value,
                                               input int               width,
                                               input logic             is_signed);
    logic [MAX_W:0] mask;
    mask = (33'd1 << width) - 33'd1;
    if (is_signed && value[width-1])
      return MAX_W'((~{1'b0, value} + 33'd1) & mask);
    return value;
  endfunction

  function automatic logic [2*MAX_W-1:0] neg2c(input logic [2*MAX_W-1:0] value);
    return ~value + 64'd1;
  endfunction

endpackage

// File: rtl/seq_array_mult_step.sv
// ----------------------------------------------------------------------------
// full_adder : one-bit full-adder cell.
// mult_step  : one combinational shift-add iteration.
//   acc      in  accumulator bits [2*WIDTH:1] (bit 0 is the multiplier LSB
//                and is shifted out, so it arrives separately as lsb)
//   lsb      in  current multiplier LSB; selects whether mcand is added
//   mcand    in  multiplicand magnitude
//   acc_next out accumulator after add-then-shift-right-by-one
// The adder is WIDTH+1 cells wide; its carry-out becomes the new top bit, so
// no carry is ever lost.
// ----------------------------------------------------------------------------
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module mult_step #(
  parameter int WIDTH = 4
) (
  input  logic [2*WIDTH:1]  acc,
  input  logic              lsb,
  input  logic [WIDTH-1:0]  mcand,
  output logic [2*WIDTH:0]  acc_next
);

  logic [WIDTH:0]   addend;
  logic [WIDTH:0]   sum;
  logic [WIDTH+1:0] carry;

  assign addend   = lsb ? {1'b0, mcand} : '0;
  assign carry[0] = 1'b0;

  for (genvar i = 0; i <= WIDTH; i++) begin : g_fa
    full_adder u_fa (
      .a   (acc[WIDTH+i]),
      .b   (addend[i]),
      .cin (carry[i]),
      .sum (sum[i]),
      .cout(carry[i+1])
    );
  end

  // Upper half gets the sum, everything moves right one place.
  assign acc_next = {carry[WIDTH+1], sum, acc[WIDTH-1:1]};

endmodule

// File: rtl/seq_array_mult.sv
// ----------------------------------------------------------------------------
// seq_array_mult
// Iterative shift-add multiplier, one partial-product row per clock, with
// unsigned and two's-complement modes. Operands are turned into magnitudes on
// accept, multiplied, and the result is negated at the end when needed.
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   operand handshake; in_a, in_b, in_signed sampled on accept
//   out_valid/out_ready result handshake; out_product held while out_valid
//   busy                high while iterating
// out_valid rises WIDTH cycles after the accept edge.
// ----------------------------------------------------------------------------
module seq_array_mult
  import mult_pkg::*;
#(
  parameter  int WIDTH = 4,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_product,
  output logic               busy
);

  localparam int PW = 2 * WIDTH;

  state_e             state_q, state_d;
  logic [PW:0]        acc_q;      // {upper WIDTH+1 sum bits, multiplier}
  logic [PW:0]        step_acc;
  logic [WIDTH-1:0]   mcand_q;
  logic               neg_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [PW-1:0]      product_q;
  logic               accept;
  logic               last;

  mult_step #(.WIDTH(WIDTH)) u_step (
    .acc     (acc_q[PW:1]),
    .lsb     (acc_q[0]),
    .mcand   (mcand_q),
    .acc_next(step_acc)
  );

  // The iteration performed while cnt_q == WIDTH-1 is the final one.
  assign last        = (cnt_q == CNT_W'(WIDTH - 1));
  assign out_product = product_q;

  // NOTE: every output of this block gets a default first so no path leaves
  // a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    accept    = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept  = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        busy = 1'b1;
        if (last) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: registers use non-blocking assignments so every flop samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q     <= '0;
      mcand_q   <= '0;
      neg_q     <= 1'b0;
      cnt_q     <= '0;
      product_q <= '0;
    end else if (accept) begin
      mcand_q <= WIDTH'(abs_mag(MAX_W'(in_a), WIDTH, in_signed));
      acc_q   <= {{(WIDTH+1){1'b0}}, WIDTH'(abs_mag(MAX_W'(in_b), WIDTH, in_signed))};
      neg_q   <= in_signed & (in_a[WIDTH-1] ^ in_b[WIDTH-1]);
      cnt_q   <= '0;
    end else if (busy) begin
      acc_q <= step_acc;
      cnt_q <= cnt_q + CNT_W'(1);
      if (last)
        product_q <= neg_q ? PW'(neg2c(64'(step_acc[PW-1:0]))) : step_acc[PW-1:0];
    end
  end

endmodule
